shift_deserializer: RTL
=======================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits (WIDTH >= 2).
REQ-002 Parameter DEPTH, default 2, output FIFO depth in words (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sin  input  1  serial data bit.
REQ-006 sin_valid  input  1  sin is valid this cycle.
REQ-007 sync  input  1  marks the current valid bit as bit 0 of a new word; ignored when sin_valid=0.
REQ-008 dir  input  1  bit order: 0 = LSB-first (right-shift source), 1 = MSB-first (left-shift source).
REQ-009 cont  input  1  1 = collect back-to-back words with no further sync.
REQ-010 clr_err  input  1  clears the sticky overrun flag.
REQ-011 out_ready  input  1  consumer accepts the dout word.
REQ-012 dout  output  WIDTH  word at the FIFO head.
REQ-013 out_valid  output  1  FIFO not empty.
REQ-014 overrun  output  1  sticky: a completed word was dropped.
REQ-015 sync_err  output  1  one-cycle pulse: a partial word was discarded by sync.
REQ-016 busy  output  1  state is COLLECT.

Function
REQ-017 FSM states SHALL be IDLE and COLLECT; a WIDTH-bit shift register and a bit counter SHALL hold the word being assembled.
REQ-018 IDLE: a cycle with sin_valid=1 and sync=0 SHALL be ignored; a cycle with sin_valid=1 and sync=1 SHALL capture sin as bit 0, latch dir, set the counter to 1 and enter COLLECT.
REQ-019 COLLECT: each cycle with sin_valid=1 and sync=0 SHALL shift in sin and increment the counter.
REQ-020 Shift rule, dir latched = 0: the register SHALL update as {sin, reg[WIDTH-1:1]}, so the first bit ends in bit 0.
REQ-021 Shift rule, dir latched = 1: the register SHALL update as {reg[WIDTH-2:0], sin}, so the first bit ends in bit WIDTH-1.
REQ-022 A change of dir during a word SHALL have no effect until the next word's first bit.
REQ-023 On the edge that captures the WIDTH-th bit, the assembled word SHALL be pushed into the FIFO; out_valid SHALL be high after that same edge if the FIFO was empty (zero-cycle added latency).
REQ-024 After a word completes, the FSM SHALL go to IDLE if cont=0, or stay in COLLECT with counter 0 and dir re-latched on the next valid bit if cont=1.
REQ-025 A cycle in COLLECT with sin_valid=1 and sync=1 SHALL discard the partial word, pulse sync_err for one cycle if the counter is nonzero, and restart with sin as bit 0.
REQ-026 A pop SHALL occur on each edge with out_valid=1 and out_ready=1; dout SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full, leaving the count unchanged.
REQ-028 A push to a full FIFO without a simultaneous pop SHALL drop the word and set overrun; FIFO contents SHALL be unchanged.
REQ-029 overrun SHALL remain set until a clr_err cycle; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While reset=1, the state SHALL be IDLE, the shift register, counter and FIFO pointers SHALL be 0, and dout=0, out_valid=0, overrun=0, sync_err=0, busy=0, independent of clk.
REQ-032 A reset asserted mid-word or with the FIFO non-empty SHALL discard all data; the first post-reset word SHALL require sync.

Structure
REQ-033 A shared package shift_deser_pkg SHALL hold the state enum (ST_IDLE, ST_COLLECT) and the DIR_LSB_FIRST=0 and DIR_MSB_FIRST=1 constants.
REQ-034 The output buffer SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/full, pop/empty interface).

Verification
REQ-035 The bench SHALL apply dir=0, cont=0, bits 0,1,0,1 (sync on the first bit), with out_ready=1 -> dout=4'b1010 and out_valid high for one cycle after the 4th bit edge, then busy=0.
REQ-036 The bench SHALL apply dir=1, bits 1,0,1,0 -> dout=4'b1010; the bench SHALL then repeat with the first bit sent without sync -> no word.
REQ-037 The bench SHALL apply cont=1, out_ready=0, and three words 4'h3, 4'h5, 4'h9 -> the FIFO holds 3 and 5, overrun=1 after the third word; out_ready=1 -> pops 3 then 5; clr_err -> overrun=0.
REQ-038 The bench SHALL apply a sync after 2 bits of a word, then 4 bits 1,1,0,0 with dir=0 -> sync_err pulses once and dout=4'b0011.
REQ-039 The bench SHALL apply a full FIFO with a simultaneous push and pop -> no overrun, and the new word appears after the older one.
REQ-040 The bench SHALL assert reset between the 2nd and 3rd bits with the FIFO holding one word -> all outputs 0; post-reset bits without sync produce no word.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input / parallel word output bundle of the deserializer.
interface shift_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic             dir;
  logic             cont;
  logic             clr_err;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             overrun;
  logic             sync_err;
  logic             busy;

  modport master (
    output sin, sin_valid, sync, dir, cont, clr_err, out_ready,
    input  dout, out_valid, overrun, sync_err, busy
  );

  modport slave (
    input  sin, sin_valid, sync, dir, cont, clr_err, out_ready,
    output dout, out_valid, overrun, sync_err, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push is accepted when full if a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNTW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Gating keeps dout at zero whenever nothing is buffered, including in reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNTW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_deserializer.sv
// Assembles serial bits into WIDTH-bit words (LSB- or MSB-first) and buffers them in a FIFO.
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  shift_deserializer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             sync_err_q, sync_err_d;
  logic             overrun_q, overrun_d;
  logic             first, eff_dir, push, pop, full, empty;
  logic [WIDTH-1:0] base, shifted;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    // First bit of a word comes from sync, or from continuous mode after a completed word.
    first   = bus.sin_valid && (bus.sync || (state_q == ST_COLLECT && cnt_q == '0));
    eff_dir = first ? bus.dir : dir_q;
    base    = first ? '0 : shreg_q;
    shifted = (eff_dir == DIR_MSB_FIRST) ? {base[WIDTH-2:0], bus.sin}
                                         : {bus.sin, base[WIDTH-1:1]};
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sin_valid && bus.sync) begin
          shreg_d = shifted;
          dir_d   = bus.dir;
          cnt_d   = CW'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.sin_valid) begin
          shreg_d = shifted;
          dir_d   = eff_dir;
          if (bus.sync) begin
            sync_err_d = (cnt_q != '0);
            cnt_d      = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = bus.cont ? ST_COLLECT : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop       = !empty && bus.out_ready;
  assign overrun_d = (push && full && !pop) ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_LSB_FIRST;
      sync_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      sync_err_q <= sync_err_d;
      overrun_q  <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (shifted),
    .full_o  (full),
    .pop_i   (pop),
    .rdata_o (bus.dout),
    .empty_o (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.overrun   = overrun_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.busy      = (state_q == ST_COLLECT);

endmodule
